// File: rtl/bridge_hs.sv
// N-device memory-mapped bridge between the MEM stage and peripherals.
// req/done handshake with device wait states and a per-access timeout.
`ifndef MEM_MODE_LEN
`define MEM_MODE_LEN 2
`endif
`ifndef MEM_MODE_READ
`define MEM_MODE_READ 2'd1
`endif
`ifndef MEM_MODE_WRITE
`define MEM_MODE_WRITE 2'd2
`endif
`ifndef EXC_CODE_LEN
`define EXC_CODE_LEN 5
`endif
`ifndef EXC_CODE_ADEL
`define EXC_CODE_ADEL 5'd4
`endif
`ifndef EXC_CODE_ADES
`define EXC_CODE_ADES 5'd5
`endif

module bridge_hs #(
  parameter int DEV_COUNT = 4,
  parameter logic [32*DEV_COUNT-1:0] DEV_BASE =
    {32'h7f30, 32'h7f20, 32'h7f10, 32'h7f00},
  parameter logic [32*DEV_COUNT-1:0] DEV_LEN = {4{32'd12}},
  parameter logic [32*DEV_COUNT-1:0] DEV_RO_ADDR = {4{32'd8}},
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req,
  input  logic [31:0]               vaddr,
  input  logic [`MEM_MODE_LEN-1:0]  mode,
  input  logic [31:0]               write_data,
  input  logic                      int_req,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               read_data,
  output logic [`EXC_CODE_LEN-1:0]  exc,
  output logic [31:0]               dev_addr,
  output logic [31:0]               dev_write_data,
  output logic [DEV_COUNT-1:0]      dev_sel,
  output logic [DEV_COUNT-1:0]      dev_write_enable,
  input  logic [32*DEV_COUNT-1:0]   dev_read_data,
  input  logic [DEV_COUNT-1:0]      dev_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t                    state_q;
  logic                      busy_q;
  logic                      done_q;
  logic [31:0]               read_data_q;
  logic [`EXC_CODE_LEN-1:0]  exc_q;
  logic [31:0]               dev_addr_q;
  logic [31:0]               dev_wdata_q;
  logic [DEV_COUNT-1:0]      dev_sel_q;
  logic [DEV_COUNT-1:0]      dev_we_q;
  logic [7:0]                cnt_q;

  logic [DEV_COUNT-1:0]      hit_oh;
  logic [31:0]               off;
  logic                      found;
  logic                      ro_hit;
  logic                      is_rd;
  logic                      is_wr;
  logic                      err;
  logic [31:0]               rd_mux;
  logic                      rdy_sel;
  logic                      acc_wr;

  // Scan from the top so the lowest matching window is the last assignment.
  always_comb begin
    hit_oh = '0;
    off    = '0;
    found  = 1'b0;
    ro_hit = 1'b0;
    for (int i = DEV_COUNT - 1; i >= 0; i--) begin
      if (vaddr >= DEV_BASE[32*i +: 32] &&
          vaddr <  DEV_BASE[32*i +: 32] + DEV_LEN[32*i +: 32]) begin
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
        off       = vaddr - DEV_BASE[32*i +: 32];
        found     = 1'b1;
        ro_hit    = (off == DEV_RO_ADDR[32*i +: 32]);
      end
    end
  end

  always_comb begin
    is_rd = (mode == `MEM_MODE_READ);
    is_wr = (mode == `MEM_MODE_WRITE);
    err   = (vaddr[1:0] != 2'b00) | ~found | (is_wr & ro_hit);
  end

  always_comb begin
    rd_mux  = '0;
    rdy_sel = 1'b0;
    for (int i = 0; i < DEV_COUNT; i++) begin
      if (dev_sel_q[i]) begin
        rd_mux  = rd_mux | dev_read_data[32*i +: 32];
        rdy_sel = rdy_sel | dev_ready[i];
      end
    end
    acc_wr = |dev_we_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      read_data_q <= '0;
      exc_q       <= '0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
      dev_sel_q   <= '0;
      dev_we_q    <= '0;
      cnt_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req && (is_rd || is_wr)) begin
            busy_q <= 1'b1;
            if (err) begin
              state_q     <= S_RESP;
              done_q      <= 1'b1;
              read_data_q <= '0;
              exc_q       <= is_wr ? `EXC_CODE_ADES
                                   : `EXC_CODE_ADEL;
            end else if (is_wr && int_req) begin
              state_q     <= S_RESP;
              done_q      <= 1'b1;
              read_data_q <= '0;
              exc_q       <= '0;
            end else begin
              state_q     <= S_ACCESS;
              dev_sel_q   <= hit_oh;
              dev_we_q    <= is_wr ? hit_oh : '0;
              dev_addr_q  <= off;
              dev_wdata_q <= write_data;
              cnt_q       <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (rdy_sel) begin
            state_q     <= S_RESP;
            done_q      <= 1'b1;
            dev_sel_q   <= '0;
            dev_we_q    <= '0;
            exc_q       <= '0;
            read_data_q <= acc_wr ? 32'd0 : rd_mux;
          end else if (cnt_q == TO_LAST) begin
            state_q     <= S_RESP;
            done_q      <= 1'b1;
            dev_sel_q   <= '0;
            dev_we_q    <= '0;
            read_data_q <= '0;
            exc_q       <= acc_wr ? `EXC_CODE_ADES
                                  : `EXC_CODE_ADEL;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign read_data        = read_data_q;
  assign exc              = exc_q;
  assign dev_addr         = dev_addr_q;
  assign dev_write_data   = dev_wdata_q;
  assign dev_sel          = dev_sel_q;
  assign dev_write_enable = dev_we_q;

endmodule

// File: tb/tb_bridge_hs.sv
// Directed self-checking bench for bridge_hs.
// One task per scenario, hand-computed expectations.
`ifndef MEM_MODE_LEN
`define MEM_MODE_LEN 2
`endif
`ifndef MEM_MODE_READ
`define MEM_MODE_READ 2'd1
`endif
`ifndef MEM_MODE_WRITE
`define MEM_MODE_WRITE 2'd2
`endif
`ifndef EXC_CODE_LEN
`define EXC_CODE_LEN 5
`endif
`ifndef EXC_CODE_ADEL
`define EXC_CODE_ADEL 5'd4
`endif
`ifndef EXC_CODE_ADES
`define EXC_CODE_ADES 5'd5
`endif

module tb_bridge_hs;

  localparam logic [`MEM_MODE_LEN-1:0] RD = `MEM_MODE_READ;
  localparam logic [`MEM_MODE_LEN-1:0] WR = `MEM_MODE_WRITE;
  localparam logic [`EXC_CODE_LEN-1:0] ADEL = `EXC_CODE_ADEL;
  localparam logic [`EXC_CODE_LEN-1:0] ADES = `EXC_CODE_ADES;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     req;
  logic [31:0]              vaddr;
  logic [`MEM_MODE_LEN-1:0] mode;
  logic [31:0]              write_data;
  logic                     int_req;
  logic                     busy;
  logic                     done;
  logic [31:0]              read_data;
  logic [`EXC_CODE_LEN-1:0] exc;
  logic [31:0]              dev_addr;
  logic [31:0]              dev_write_data;
  logic [3:0]               dev_sel;
  logic [3:0]               dev_write_enable;
  logic [127:0]             dev_read_data;
  logic [3:0]               dev_ready;

  int total = 0;
  int bad = 0;

  int lat, selc, wec;
  logic [3:0] selv, wev;
  logic d2;

  bridge_hs dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .vaddr            (vaddr),
    .mode             (mode),
    .write_data       (write_data),
    .int_req          (int_req),
    .busy             (busy),
    .done             (done),
    .read_data        (read_data),
    .exc              (exc),
    .dev_addr         (dev_addr),
    .dev_write_data   (dev_write_data),
    .dev_sel          (dev_sel),
    .dev_write_enable (dev_write_enable),
    .dev_read_data    (dev_read_data),
    .dev_ready        (dev_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and tracks strobes until done (bounded at 40 cycles).
  task automatic run_access(
    input  logic [31:0]              a,
    input  logic [`MEM_MODE_LEN-1:0] m,
    input  logic [31:0]              wd,
    input  logic                     ir,
    input  int                       rdev,
    input  int                       rat,
    output int                       l,
    output int                       sc,
    output logic [3:0]               sv,
    output int                       wc,
    output logic [3:0]               wv,
    output logic                     dn2
  );
    req = 1'b1;
    vaddr = a;
    mode = m;
    write_data = wd;
    int_req = ir;
    dev_ready = '0;
    sc = 0;
    sv = '0;
    wc = 0;
    wv = '0;
    step();
    req = 1'b0;
    l = 1;
    while (done !== 1'b1 && l < 40) begin
      if (dev_sel != 4'b0) begin
        sc++;
        sv |= dev_sel;
      end
      if (dev_write_enable != 4'b0) begin
        wc++;
        wv |= dev_write_enable;
      end
      if (rdev >= 0 && l >= rat) dev_ready = 4'(1 << rdev);
      step();
      l++;
    end
    dev_ready = '0;
    int_req = 1'b0;
    step();
    dn2 = done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy_done got=%b%b want=00", busy, done);
    end
    total++;
    if (dev_sel !== 4'b0 || dev_write_enable !== 4'b0) begin
      bad++;
      $display("FAIL rst_strobes got=%b/%b want=0000/0000",
               dev_sel, dev_write_enable);
    end
    total++;
    if (read_data !== 32'd0 || exc !== '0) begin
      bad++;
      $display("FAIL rst_rdata_exc got=%h/%h want=0/0", read_data, exc);
    end
    total++;
    if (dev_addr !== 32'd0 || dev_write_data !== 32'd0) begin
      bad++;
      $display("FAIL rst_dev_regs got=%h/%h want=0/0",
               dev_addr, dev_write_data);
    end
  endtask

  task automatic test_read_zero_wait();
    run_access(32'h7f04, RD, 32'd0, 1'b0, 0, 1,
               lat, selc, selv, wec, wev, d2);
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL rd_lat got=%0d want=2", lat);
    end
    total++;
    if (selc !== 1 || selv !== 4'b0001) begin
      bad++;
      $display("FAIL rd_sel got=%0d/%b want=1/0001", selc, selv);
    end
    total++;
    if (wec !== 0) begin
      bad++;
      $display("FAIL rd_no_we got=%0d want=0", wec);
    end
    total++;
    if (read_data !== 32'h1234 || exc !== '0) begin
      bad++;
      $display("FAIL rd_data got=%h/%h want=1234/0", read_data, exc);
    end
    total++;
    if (dev_addr !== 32'd4) begin
      bad++;
      $display("FAIL rd_addr got=%h want=4", dev_addr);
    end
    total++;
    if (d2 !== 1'b0) begin
      bad++;
      $display("FAIL rd_done_pulse got=%b want=0", d2);
    end
  endtask

  task automatic test_errors();
    run_access(32'h7f18, WR, 32'hdead, 1'b0, 1, 1,
               lat, selc, selv, wec, wev, d2);
    total++;
    if (lat !== 1 || wec !== 0 || exc !== ADES) begin
      bad++;
      $display("FAIL ro_write got=%0d/%0d/%h want=1/0/%h",
               lat, wec, exc, ADES);
    end
    run_access(32'h7f02, RD, 32'd0, 1'b0, 0, 1,
               lat, selc, selv, wec, wev, d2);
    total++;
    if (lat !== 1 || selc !== 0 || exc !== ADEL) begin
      bad++;
      $display("FAIL misalign got=%0d/%0d/%h want=1/0/%h",
               lat, selc, exc, ADEL);
    end
    run_access(32'h8000, RD, 32'd0, 1'b0, 0, 1,
               lat, selc, selv, wec, wev, d2);
    total++;
    if (lat !== 1 || exc !== ADEL || read_data !== 32'd0) begin
      bad++;
      $display("FAIL no_hit got=%0d/%h/%h want=1/%h/0",
               lat, exc, read_data, ADEL);
    end
  endtask

  task automatic test_store_paths();
    run_access(32'h7f20, WR, 32'hcafe, 1'b1, 2, 1,
               lat, selc, selv, wec, wev, d2);
    total++;
    if (lat !== 1 || wec !== 0 || selc !== 0 || exc !== '0) begin
      bad++;
      $display("FAIL int_store got=%0d/%0d/%0d/%h want=1/0/0/0",
               lat, wec, selc, exc);
    end
    run_access(32'h7f20, WR, 32'hcafe, 1'b0, 2, 4,
               lat, selc, selv, wec, wev, d2);
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL wait_store_lat got=%0d want=5", lat);
    end
    total++;
    if (wec !== 4 || wev !== 4'b0100) begin
      bad++;
      $display("FAIL wait_store_we got=%0d/%b want=4/0100", wec, wev);
    end
    total++;
    if (exc !== '0 || read_data !== 32'd0 || dev_write_data !== 32'hcafe) begin
      bad++;
      $display("FAIL wait_store_res got=%h/%h/%h want=0/0/cafe",
               exc, read_data, dev_write_data);
    end
  endtask

  task automatic test_timeout();
    run_access(32'h7f30, RD, 32'd0, 1'b0, -1, 1,
               lat, selc, selv, wec, wev, d2);
    total++;
    if (lat !== 16 || selc !== 15 || selv !== 4'b1000) begin
      bad++;
      $display("FAIL tmo_lat got=%0d/%0d/%b want=16/15/1000",
               lat, selc, selv);
    end
    total++;
    if (exc !== ADEL || read_data !== 32'd0) begin
      bad++;
      $display("FAIL tmo_res got=%h/%h want=%h/0", exc, read_data, ADEL);
    end
  endtask

  task automatic test_bad_mode();
    req = 1'b1;
    vaddr = 32'h7f04;
    mode = '0;
    step();
    req = 1'b0;
    total++;
    if (busy !== 1'b0 || dev_sel !== 4'b0) begin
      bad++;
      $display("FAIL bad_mode got=%b/%b want=0/0000", busy, dev_sel);
    end
    step();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL bad_mode_done got=%b want=0", done);
    end
  endtask

  task automatic test_req_while_busy();
    logic seen_busy0;
    req = 1'b1;
    vaddr = 32'h7f14;
    mode = RD;
    step();
    vaddr = 32'h7f00;
    selv = '0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      selv |= dev_sel;
      if (lat >= 3) begin
        req = 1'b0;
        dev_ready = 4'b0010;
      end
      step();
      lat++;
    end
    req = 1'b0;
    dev_ready = '0;
    total++;
    if (lat !== 4 || selv !== 4'b0010) begin
      bad++;
      $display("FAIL busy_req got=%0d/%b want=4/0010", lat, selv);
    end
    total++;
    if (read_data !== 32'hbbbb0001) begin
      bad++;
      $display("FAIL busy_req_data got=%h want=bbbb0001", read_data);
    end
    seen_busy0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (busy !== 1'b0) seen_busy0 = 1'b0;
    end
    total++;
    if (seen_busy0 !== 1'b1) begin
      bad++;
      $display("FAIL busy_req_queued got=%b want=1", seen_busy0);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    req = 1'b1;
    vaddr = 32'h7f30;
    mode = RD;
    step();
    req = 1'b0;
    step();
    total++;
    if (dev_sel !== 4'b1000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre got=%b/%b want=1000/1", dev_sel, busy);
    end
    reset = 1'b1;
    step();
    total++;
    if (busy !== 1'b0 || dev_sel !== 4'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst got=%b/%b/%b want=0/0000/0",
               busy, dev_sel, done);
    end
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done === 1'b1) seen_done = 1'b1;
    end
    total++;
    if (seen_done !== 1'b0) begin
      bad++;
      $display("FAIL mid_no_done got=%b want=0", seen_done);
    end
    run_access(32'h7f04, RD, 32'd0, 1'b0, 0, 1,
               lat, selc, selv, wec, wev, d2);
    total++;
    if (lat !== 2 || read_data !== 32'h1234 || exc !== '0) begin
      bad++;
      $display("FAIL mid_after got=%0d/%h/%h want=2/1234/0",
               lat, read_data, exc);
    end
  endtask

  initial begin
    reset = 1'b1;
    req = 1'b0;
    vaddr = '0;
    mode = '0;
    write_data = '0;
    int_req = 1'b0;
    dev_ready = '0;
    dev_read_data = {32'hdddd0003, 32'hcccc0002,
                     32'hbbbb0001, 32'h00001234};
    #1;
    test_reset();
    test_read_zero_wait();
    test_errors();
    test_store_paths();
    test_timeout();
    test_bad_mode();
    test_req_while_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
